// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM state encoding and iteration count
package muldiv_pkg;

  localparam int ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

  // Multiply and divide ops occupy codes 0-3 and run through the iterative datapath.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 multiply (shift-add) or divide (restoring) step
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  mode_t              mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_sub;
  logic           rem_ge;

  // Multiply: acc = {partial product, remaining multiplier bits}, add then shift right.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shift left then trial-subtract.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, operand});
    rem_sub  = rem_sh - {1'b0, operand};
    acc_next = '0;
    if (mode == MODE_MUL) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (rem_ge) begin
      acc_next = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential 32-step MIPS-style multiply/divide unit with HI/LO
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  state_t             state;
  state_t             state_d;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;
  mode_t              mode;
  logic               sgn;
  logic               sign_a;
  logic               sign_b;
  logic               div0;

  logic               accept;
  logic               step_en;
  logic               fix_wr;
  logic               mt_hi;
  logic               mt_lo;

  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .mode     (mode),
    .acc_next (acc_step)
  );

  // Operand decode: signed ops iterate on magnitudes, signs are restored in FIXUP.
  always_comb begin
    op_signed = is_signed_op(op);
    op_div    = is_div_op(op);
    mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
  end

  // Sign correction and HI/LO selection from the finished accumulator.
  always_comb begin
    prod_fix = (sgn && (sign_a ^ sign_b)) ? -acc : acc;
    res_hi   = '0;
    res_lo   = '0;
    if (mode == MODE_MUL) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else begin
      // With a zero divisor the remainder already reconstructs the original dividend.
      res_hi = (sgn && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (div0) begin
        res_lo = '1;
      end else begin
        res_lo = (sgn && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  // Next-state and control strobes; flush beats start, start only counts in IDLE.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    step_en = 1'b0;
    fix_wr  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          if (is_iter_op(op)) begin
            accept  = 1'b1;
            state_d = ST_RUN;
          end else if (op == OP_MTHI) begin
            mt_hi = 1'b1;
          end else if (op == OP_MTLO) begin
            mt_lo = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            state_d = ST_FIXUP;
          end
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        if (!flush) begin
          fix_wr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != ST_IDLE);
      done  <= fix_wr;
    end
  end

  // Datapath: operand latch on accept, one step per RUN cycle, HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      mode   <= MODE_MUL;
      sgn    <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        acc    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
        opnd   <= op_div ? mag_b : mag_a;
        mode   <= op_div ? MODE_DIV : MODE_MUL;
        sgn    <= op_signed;
        sign_a <= a[WIDTH-1];
        sign_b <= b[WIDTH-1];
        div0   <= op_div && (b == '0);
      end else if (step_en) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (fix_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (mt_hi) begin
        hi <= a;
      end
      if (mt_lo) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq with directed vectors
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h", hi, lo);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check32({e.name, "_hi"}, hi, e.hi);
          check32({e.name, "_lo"}, lo, e.lo);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    step();
    start = 1'b0;
    k     = 0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      check32({name, "_latency"}, 32'(k), 32'd33);
      check32({name, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.name = name;
    sb.push_back(e);
    issue(o, av, bv);
    check32({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(name);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    rst = 1'b0;
    step();

    run_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_by_zero", OP_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MULTU with an MTLO request arriving at edge 10 while busy
    begin
      exp_t e;
      e.hi = 32'hFFFF_FFFE;
      e.lo = 32'h0000_0001;
      e.name = "multu_max";
      sb.push_back(e);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) step();
      start = 1'b1;
      op    = OP_MTLO;
      a     = 32'h0000_5A5A;
      step();
      start = 1'b0;
      check32("mtlo_busy_ignored_lo", lo, 32'h8000_0000);
      check32("mtlo_busy_still_busy", 32'(busy), 32'd1);
      wait_done("multu_max");
    end

    // MTHI in IDLE
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'hDEAD_BEEF;
    step();
    start = 1'b0;
    check32("mthi_hi", hi, 32'hDEAD_BEEF);
    check32("mthi_busy", 32'(busy), 32'd0);
    check32("mthi_lo_kept", lo, 32'h0000_0001);

    // MTHI together with flush is dropped
    start = 1'b1;
    flush = 1'b1;
    op    = OP_MTHI;
    a     = 32'h0000_0055;
    step();
    start = 1'b0;
    flush = 1'b0;
    check32("mthi_flush_hi", hi, 32'hDEAD_BEEF);

    // Unused op code 6 does nothing
    start = 1'b1;
    op    = 3'd6;
    a     = 32'h1111_1111;
    step();
    start = 1'b0;
    step();
    check32("op6_busy", 32'(busy), 32'd0);
    check32("op6_hi", hi, 32'hDEAD_BEEF);
    check32("op6_lo", lo, 32'h0000_0001);

    // DIVU flushed at edge 15
    issue(OP_DIVU, 32'd50, 32'd3);
    repeat (14) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check32("flush_busy", 32'(busy), 32'd0);
    repeat (40) step();
    check32("flush_hi_kept", hi, 32'hDEAD_BEEF);
    check32("flush_lo_kept", lo, 32'h0000_0001);

    // MULT interrupted by reset at edge 20
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check32("midrst_busy", 32'(busy), 32'd0);
    check32("midrst_done", 32'(done), 32'd0);
    check32("midrst_hi", hi, 32'd0);
    check32("midrst_lo", lo, 32'd0);
    repeat (40) step();

    run_op("divu_9_4", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);
    repeat (3) step();

    check32("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
